// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants for the memory controller.
//   state_t      - controller FSM state encoding
//   LEN_*        - lsb_len access-size codes
//   OP_*         - load/store opcode field values used by the LSB
//   is_io_addr() - memory-mapped IO decode (addr[17:16] == 2'b11)
//   len_to_bytes - access-size code to byte count
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] IO_SEL = 2'b11;

  function automatic logic is_io_addr(input logic [31:0] a);
    return a[17:16] == IO_SEL;
  endfunction

  // Unused code 3 is treated as a word access.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM controller serving instruction fetch (ic) and
// load/store (lsb) requesters, one transaction at a time.
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable)
//   mem_din/mem_dout/mem_a/mem_wr  - byte RAM, 1-cycle read latency
//   io_buffer_full                 - stalls writes to IO space
//   rob_clear                      - flush; aborts reads, never stores
//   ic_req/ic_addr -> ic_ready/ic_data           (word fetch)
//   lsb_req/wr/len/addr/wdata -> lsb_ready/lsb_rdata (zero-extended load)
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        rob_clear,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_ready,
  output logic [31:0] ic_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ready,
  output logic [31:0] lsb_rdata
);

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;      // edges since accept (read) / bytes written (write)
  logic [2:0]  r_n;        // transaction byte count
  logic        r_lsb;      // owner: 1 = lsb, 0 = ic
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;      // read bytes assembled so far
  logic [31:0] r_ic_data;
  logic [31:0] r_lsb_rdata;
  // While frozen the RAM keeps reading the held address, so the byte that was
  // in flight when rdy_in dropped is parked here and used on the resume edge.
  logic [7:0]  r_hold;
  logic        r_stall;

  logic [31:0] w_byte_a;
  logic        w_io_blk;
  logic        w_accept;
  logic [7:0]  w_din;
  logic [1:0]  w_bsel;
  logic [31:0] w_merged;

  assign w_byte_a = r_addr + {29'd0, r_cnt};
  assign w_io_blk = is_io_addr(w_byte_a) && io_buffer_full;
  assign w_accept = (r_state == ST_IDLE) && !rob_clear && (lsb_req || ic_req);
  assign w_din    = r_stall ? r_hold : mem_din;
  // At count c the byte arriving is byte c-1.
  assign w_bsel   = r_cnt[1:0] - 2'd1;
  assign w_merged = r_buf | ({24'd0, w_din} << {w_bsel, 3'b000});

  assign ic_data   = r_ic_data;
  assign lsb_rdata = r_lsb_rdata;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_a     = 32'd0;
    mem_dout  = 8'd0;
    mem_wr    = 1'b0;
    ic_ready  = 1'b0;
    lsb_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = (lsb_req && lsb_wr) ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        if (r_cnt < r_n) mem_a = w_byte_a;
        if (rob_clear)           w_next = ST_IDLE;
        else if (r_cnt == r_n)   w_next = ST_DONE;
      end
      ST_WRITE: begin
        mem_a    = w_byte_a;
        mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        mem_wr   = rdy_in && !w_io_blk;
        if (!w_io_blk && (r_cnt == r_n - 3'd1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        ic_ready  = rdy_in && !r_lsb;
        lsb_ready = rdy_in && r_lsb;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (!rdy_in) w_next = r_state;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_lsb       <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_ic_data   <= 32'd0;
      r_lsb_rdata <= 32'd0;
      r_hold      <= 8'd0;
      r_stall     <= 1'b0;
    end else if (!rdy_in) begin
      if (!r_stall) r_hold <= mem_din;
      r_stall <= 1'b1;
    end else begin
      r_stall <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= 3'd0;
            r_buf <= 32'd0;
            if (lsb_req) begin
              r_lsb   <= 1'b1;
              r_addr  <= lsb_addr;
              r_wdata <= lsb_wdata;
              r_n     <= len_to_bytes(lsb_len);
            end else begin
              r_lsb   <= 1'b0;
              r_addr  <= ic_addr;
              r_wdata <= 32'd0;
              r_n     <= 3'd4;
            end
          end
        end
        ST_READ: begin
          if (!rob_clear) begin
            if (r_cnt != 3'd0) r_buf <= w_merged;
            if (r_cnt == r_n) begin
              if (r_lsb) r_lsb_rdata <= w_merged;
              else       r_ic_data   <= w_merged;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          if (!w_io_blk) r_cnt <= r_cnt + 3'd1;
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

endmodule
